// File: rtl/edge_event_logger_pkg.sv
// Shared record layout and constants for the edge event logger.
// A record is {ts, a, b, a&b, edge_a, edge_b} with the timestamp in the MSBs.
package event_log_pkg;

  localparam int EB_BIT      = 0;
  localparam int EA_BIT      = 1;
  localparam int X_BIT       = 2;
  localparam int B_BIT       = 3;
  localparam int A_BIT       = 4;
  localparam int TS_LSB      = 5;
  localparam int EVT_CNT_MAX = 255;

  function automatic int REC_W(input int ts_w);
    return ts_w + TS_LSB;
  endfunction

endpackage

// File: rtl/edge_event_logger_if.sv
// Record read port. Handshake: a record transfers on a rising clk edge where
// out_valid & rd_ready; out_data is held stable while out_valid & ~rd_ready.
interface edge_event_logger_if #(
    parameter int W = 21
) ();

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         rd_ready;

    modport master (output out_valid, output out_data, input rd_ready);
    modport slave  (input out_valid, input out_data, output rd_ready);

endinterface

// File: rtl/edge_event_logger_sync_fifo.sv
// Register-array FIFO: the head entry is read straight from flops, so dout
// has no path from the write port. Pop is ignored when empty, push when full
// unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointers are power-of-two wide, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_logger.sv
// Rising-edge event logger: timestamps edges on a/b, pulses trig, counts
// events and buffers records in a FIFO drained over the rec_if handshake.
module edge_event_logger
    import event_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    input  logic                   b,
    edge_event_logger_if.master    rec_if,
    output logic                   trig,
    output logic [7:0]             evt_cnt,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int RW = REC_W(TS_W);
    localparam logic [7:0] CNT_MAX = 8'(EVT_CNT_MAX);

    logic            a_q, b_q;
    logic [TS_W-1:0] ts_q;
    logic            trig_q;
    logic [7:0]      evt_cnt_q;
    logic            overflow_q;
    logic            edge_a, edge_b, event_w;
    logic            pop, full, empty;
    logic [RW-1:0]   rec;

    assign edge_a  = a & ~a_q;
    assign edge_b  = b & ~b_q;
    assign event_w = edge_a | edge_b;
    assign pop     = ~empty & rec_if.rd_ready;

    always_comb begin
        rec                   = '0;
        rec[TS_LSB +: TS_W]   = ts_q;
        rec[A_BIT]            = a;
        rec[B_BIT]            = b;
        rec[X_BIT]            = a & b;
        rec[EA_BIT]           = edge_a;
        rec[EB_BIT]           = edge_b;
    end

    sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (event_w),
        .pop_i   (pop),
        .din_i   (rec),
        .dout_o  (rec_if.out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // Dropped events still pulse trig and count; only the record is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            ts_q       <= '0;
            trig_q     <= 1'b0;
            evt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            ts_q   <= ts_q + 1'b1;
            trig_q <= event_w;
            if (event_w && evt_cnt_q != CNT_MAX) evt_cnt_q <= evt_cnt_q + 1'b1;
            if (event_w && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign rec_if.out_valid = ~empty;
    assign trig             = trig_q;
    assign evt_cnt          = evt_cnt_q;
    assign overflow         = overflow_q;

endmodule

// File: doc/edge_event_logger.md
# edge_event_logger

- Sits directly downstream of the region-exercise stimulus block and consumes its synchronous `a`/`b` outputs.
- Detects rising edges on `a` or `b`, stamps each edge event with a free-running cycle timestamp, and raises a one-cycle `trig` pulse.
- Stores event records in a small FIFO that a consumer drains over a valid/ready handshake.
- Gives the team a synthesizable, checkable record of event ordering in place of `$display`/`$strobe` observation.

## Interface
- `DEPTH`, default 8, FIFO entries; power of two, ≥2.
- `TS_W`, default 16, timestamp width.
- `clk`  input  1  clock; all logic on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high. Clears all state.
- `a`  input  1  event source A, synchronous to `clk`.
- `b`  input  1  event source B, synchronous to `clk`.
- `rd_ready`  input  1  consumer accepts the head record.
- `out_valid`  output  1  head record valid.
- `out_data`  output  TS_W+5  record `{ts, a, b, x, edge_a, edge_b}`, with `ts` in the MSBs.
- `trig`  output  1  one-cycle pulse per event.
- `evt_cnt`  output  8  count of detected events, saturating at 255.
- `level`  output  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  output  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- **Input sampling.**
  - `a_q`/`b_q` register `a`/`b` every cycle; both reset to 0.
  - `edge_a = a & ~a_q`, `edge_b = b & ~b_q`.
  - `event = edge_a | edge_b`.
- **Timestamp.** `ts` increments by 1 every cycle, resets to 0, and wraps from 2^TS_W−1 to 0 with no flag.
- **Record.** On `event`, the record `{ts, a, b, a&b, edge_a, edge_b}` is built from the current (pre-edge) `ts` and the current `a`/`b`.
  - Falling edges generate nothing.
  - Both edges in the same cycle produce one record with both edge bits set.
- **Push.** A record is pushed when `event` is high and either the FIFO is not full or a pop happens in the same cycle.
  - If the FIFO is full with no pop, the record is dropped and `overflow` is set.
  - `overflow` is cleared only by `rst`.
- **Pop.** A pop occurs when `out_valid & rd_ready`.
  - `rd_ready` while empty has no effect.
  - `out_data` is the registered head entry and is stable while `out_valid & ~rd_ready`.
- **Simultaneous push and pop.**
  - `level` is unchanged.
  - When `level==1`, the new record becomes head on the next cycle.
- **Event counter.**
  - `trig` is registered: high for exactly the one cycle after the edge at which `event` was seen. Dropped events still pulse `trig`.
  - `evt_cnt` increments on every event, dropped ones included, and saturates at 255.

## Timing
- **Reset values.** `out_valid=0`, `out_data=0`, `trig=0`, `evt_cnt=0`, `level=0`, `overflow=0`, `ts=0`, read/write pointers=0.
- **Latency.** The input rises before edge N, so `event` is high during the cycle ending at edge N. After edge N:
  - `trig=1`,
  - the record is stored,
  - `out_valid=1` if the FIFO was empty.
- There is no combinational fall-through from input to `out_valid`.
- **Edge count.** With `a` held at 1 from reset release, the first clock edge logs exactly one event with `ts=0`. No further events occur while `a` stays high.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Full/empty come from `level` (or an extra pointer MSB); full ⇔ `level==DEPTH`.
- **Reset mid-operation.**
  - Asserting `rst` clears all state immediately (asynchronous).
  - Buffered records are discarded.
  - After deassertion, `a_q=0`, so a still-high input produces a fresh event at the first edge.

## Structure
- Package `event_log_pkg`:
  - record field offsets (`TS_LSB`, `A_BIT`, `B_BIT`, `X_BIT`, `EA_BIT`, `EB_BIT`),
  - `REC_W(TS_W)` helper,
  - `EVT_CNT_MAX=255`.
- Sub-module `sync_fifo`: parameterized width/depth, push/pop/full/empty/level, same `clk`/`rst`.
- Top-level logic: edge detect, timestamp, `trig`/`evt_cnt`/`overflow`.

## Test plan
- **Single edge.** Reset, then raise `a` before edge 1, `rd_ready=0`.
  - `trig` is high for one cycle.
  - `out_valid=1` with `out_data` = ts 0, a=1, b=0, x=0, edge_a=1, edge_b=0.
  - `level=1`, `evt_cnt=1`.
- **Dual edge.** Raise `a` and `b` together at the cycle with ts=5.
  - Exactly one record: ts 5, a=1, b=1, x=1, edge_a=1, edge_b=1.
  - `evt_cnt` +1.
- **Overflow.** With `rd_ready=0`, toggle `a` to create 10 events (DEPTH=8).
  - `level` saturates at 8 and `overflow=1`.
  - `evt_cnt=10`, `trig` pulses 10 times.
  - Draining returns the first 8 timestamps in order.
- **Push and pop when full.** With FIFO full, an event coincides with `rd_ready=1`.
  - Push is accepted, `level` stays 8, no new overflow.
  - The new record appears last in drain order.
- **Backpressure and wrap.** Use `TS_W=4` and drain with `rd_ready` alternating.
  - `out_data` is held stable while stalled.
  - The timestamp reads 15 and then 0 across the wrap.
- **Mid-operation reset.** Assert `rst` mid-drain with `level=3` and `a` held high.
  - All outputs read 0 immediately.
  - After release, the first edge logs ts 0 with edge_a=1.
